// File: rtl/rx_frame_ctrl_pkg.sv
// Shared framing definitions for the serial receive path: delimiter codes,
// FSM state encoding and the receiver oversampling factor.
package rx_frame_ctrl_pkg;

  localparam logic [7:0]  SOF_CODE   = 8'h02;
  localparam logic [7:0]  EOF_CODE   = 8'h03;
  localparam int unsigned BIT_PERIOD = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/rx_frame_ctrl_byte_event.sv
// Turns the receiver's per-byte completion level into a one-cycle byte event.
// History resets to 1 so a level already high out of reset is not a new byte.
module rx_byte_event (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_received,
  input  logic [7:0] rx_byte,
  output logic       byte_evt,
  output logic [7:0] evt_byte
);

  logic rx_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_prev <= 1'b1;
    else        rx_prev <= rx_received;
  end

  // Byte is used in the same cycle as the rising edge; it is stable while rx_received is high.
  assign byte_evt = rx_received & ~rx_prev;
  assign evt_byte = rx_byte;

endmodule

// File: rtl/rx_frame_ctrl.sv
// Collects SOF..EOF delimited frames from the byte receiver and presents them
// on a valid/ready port, with overflow, inter-byte timeout and drop flags.
module rx_frame_ctrl
  import rx_frame_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 15,
  parameter logic [7:0]  SOF_BYTE    = SOF_CODE,
  parameter logic [7:0]  EOF_BYTE    = EOF_CODE,
  parameter int unsigned TIMEOUT_CYC = 4 * 10 * BIT_PERIOD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_received,
  input  logic [7:0]           rx_byte,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [8*MAX_LEN-1:0] frame_data,
  output logic [3:0]           frame_len,
  output logic                 busy,
  output logic                 err_overflow,
  output logic                 err_timeout,
  output logic                 err_drop
);

  localparam int unsigned     TW      = $clog2(TIMEOUT_CYC);
  localparam logic [3:0]      LEN_MAX = 4'(MAX_LEN);
  localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT_CYC - 1);

  if (MAX_LEN < 1 || MAX_LEN > 15) begin : g_bad_max_len
    $error("rx_frame_ctrl: MAX_LEN must be 1..15 to fit the 4-bit length");
  end

  state_e               state, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           len_q, len_d;
  logic [8*MAX_LEN-1:0] data_q, data_d;
  logic                 ovf_q, ovf_d, to_q, to_d, drop_q, drop_d;
  logic                 byte_evt;
  logic [7:0]           evt_byte;

  rx_byte_event u_byte_event (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_received (rx_received),
    .rx_byte     (rx_byte),
    .byte_evt    (byte_evt),
    .evt_byte    (evt_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      len_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state;
    timer_d = '0;
    len_d   = len_q;
    data_d  = data_q;
    ovf_d   = 1'b0;
    to_d    = 1'b0;
    drop_d  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (byte_evt && evt_byte == SOF_BYTE) begin
          state_d = ST_COLLECT;
          len_d   = '0;
          data_d  = '0;
        end
      end
      ST_COLLECT: begin
        // A byte event takes priority over an expiring timer in the same cycle.
        if (byte_evt) begin
          if (evt_byte == EOF_BYTE) begin
            state_d = (len_q != '0) ? ST_HOLD : ST_IDLE;
          end else if (evt_byte == SOF_BYTE) begin
            len_d  = '0;
            data_d = '0;
          end else if (len_q == LEN_MAX) begin
            ovf_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
              if (len_q == 4'(k)) data_d[8*k +: 8] = evt_byte;
            end
            len_d = len_q + 4'd1;
          end
        end else if (timer_q == T_LAST) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_HOLD: begin
        drop_d = byte_evt;
        if (frame_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_valid  = (state == ST_HOLD);
    busy         = (state != ST_IDLE);
    frame_data   = data_q;
    frame_len    = len_q;
    err_overflow = ovf_q;
    err_timeout  = to_q;
    err_drop     = drop_q;
  end

endmodule
